lfsr_rng_param: RTL and testbench

Parametrised pseudo-random draw generator for the note/lane spawner. It is built around a Fibonacci LFSR of configurable width and tap set, and delivers `OUT_W`-bit values on a req/valid handshake. Each draw advances the LFSR a configurable number of steps, and values at or above `MAX_VAL` are rejected and redrawn, so only in-range values (lane numbers, delays) reach the game FSM. The block also supports runtime reseeding with all-zero lock-up protection.

---
 rtl/lfsr_rng_param.sv | 103 ++++++++++
 tb/tb_lfsr_rng_param.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rng_param.sv
// Parametrised LFSR-based random draw generator with rejection sampling,
// req/valid handshake and runtime reseeding for the note/lane spawner.
module lfsr_rng_param #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] TAPS     = 16'hB400,
    parameter logic [WIDTH-1:0] SEED     = 16'hACE1,
    parameter int               OUT_W    = 4,
    parameter int               STEPS    = 13,
    parameter int               MAX_VAL  = 16,
    parameter bit               FREE_RUN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    output logic             busy,
    output logic             valid,
    output logic [OUT_W-1:0] rnd,
    output logic [7:0]       rejects
);
    localparam int                CNT_W    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(STEPS - 1);
    // One extra bit so MAX_VAL = 2^OUT_W is representable and accepts everything.
    localparam logic [OUT_W:0]    MAX_C    = (OUT_W + 1)'(MAX_VAL);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} fsm_t;

    fsm_t             st_q, st_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d, lfsr_step;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] rnd_q, rnd_d, cand;
    logic             valid_q, valid_d;
    logic [7:0]       rej_q, rej_d;

    assign lfsr_step = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
    assign cand      = lfsr_q[WIDTH-1 -: OUT_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= IDLE;
            lfsr_q  <= SEED;
            cnt_q   <= '0;
            rnd_q   <= '0;
            valid_q <= 1'b0;
            rej_q   <= '0;
        end else begin
            st_q    <= st_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            rnd_q   <= rnd_d;
            valid_q <= valid_d;
            rej_q   <= rej_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        rnd_d   = rnd_q;
        valid_d = 1'b0;
        rej_d   = rej_q;
        if (seed_load) begin
            // A zero seed would lock the LFSR up, so fall back to SEED.
            lfsr_d = (seed_in == '0) ? SEED : seed_in;
            st_d   = IDLE;
            rej_d  = '0;
        end else begin
            case (st_q)
                IDLE: begin
                    if (FREE_RUN) lfsr_d = lfsr_step;
                    if (req) begin
                        cnt_d = CNT_INIT;
                        st_d  = SHIFT;
                    end
                end
                SHIFT: begin
                    lfsr_d = lfsr_step;
                    if (cnt_q == '0) st_d = CHECK;
                    else             cnt_d = cnt_q - 1'b1;
                end
                CHECK: begin
                    if ({1'b0, cand} < MAX_C) begin
                        rnd_d   = cand;
                        valid_d = 1'b1;
                        st_d    = IDLE;
                    end else begin
                        if (rej_q != 8'hFF) rej_d = rej_q + 8'd1;
                        cnt_d = CNT_INIT;
                        st_d  = SHIFT;
                    end
                end
                default: st_d = IDLE;
            endcase
        end
    end

    assign busy    = (st_q != IDLE);
    assign valid   = valid_q;
    assign rnd     = rnd_q;
    assign rejects = rej_q;
endmodule

// File: tb/tb_lfsr_rng_param.sv
// Randomized bench for lfsr_rng_param: three configurations checked against a
// transaction-level model that predicts each draw's value, latency and rejects.
module tb_lfsr_rng_param;
    localparam int N = 3;
    localparam int W  [N] = '{4, 5, 4};
    localparam int TP [N] = '{12, 20, 12};
    localparam int SD [N] = '{1, 19, 1};
    localparam int OW [N] = '{2, 3, 4};
    localparam int ST [N] = '{1, 3, 1};
    localparam int MX [N] = '{3, 5, 16};
    localparam int FR [N] = '{0, 1, 0};

    logic       clk = 1'b0;
    logic       rst_v   [N];
    logic       sl_v    [N];
    logic       req_v   [N];
    logic       busy_v  [N];
    logic       valid_v [N];
    logic [7:0] rej_v   [N];
    logic [3:0] sin0, sin2;
    logic [4:0] sin1;
    logic [1:0] rnd0;
    logic [2:0] rnd1;
    logic [3:0] rnd2;

    int ms [N];
    int mrnd [N];
    int mrej [N];
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    lfsr_rng_param #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'b0001), .OUT_W(2),
                     .STEPS(1), .MAX_VAL(3), .FREE_RUN(1'b0)) d0 (
        .clk(clk), .rst(rst_v[0]), .seed_load(sl_v[0]), .seed_in(sin0), .req(req_v[0]),
        .busy(busy_v[0]), .valid(valid_v[0]), .rnd(rnd0), .rejects(rej_v[0]));

    lfsr_rng_param #(.WIDTH(5), .TAPS(5'b10100), .SEED(5'b10011), .OUT_W(3),
                     .STEPS(3), .MAX_VAL(5), .FREE_RUN(1'b1)) d1 (
        .clk(clk), .rst(rst_v[1]), .seed_load(sl_v[1]), .seed_in(sin1), .req(req_v[1]),
        .busy(busy_v[1]), .valid(valid_v[1]), .rnd(rnd1), .rejects(rej_v[1]));

    lfsr_rng_param #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'b0001), .OUT_W(4),
                     .STEPS(1), .MAX_VAL(16), .FREE_RUN(1'b0)) d2 (
        .clk(clk), .rst(rst_v[2]), .seed_load(sl_v[2]), .seed_in(sin2), .req(req_v[2]),
        .busy(busy_v[2]), .valid(valid_v[2]), .rnd(rnd2), .rejects(rej_v[2]));

    // Reference LFSR step: feedback is the parity of the tapped bits.
    function automatic int step(input int k, input int s);
        int fb;
        fb = $countones(s & TP[k]) % 2;
        return ((s << 1) | fb) & ((1 << W[k]) - 1);
    endfunction

    function automatic int cand(input int k, input int s);
        return s >> (W[k] - OW[k]);
    endfunction

    function automatic int rnd_of(input int k);
        case (k)
            0:       return int'(rnd0);
            1:       return int'(rnd1);
            default: return int'(rnd2);
        endcase
    endfunction

    function automatic int bv(input int k);
        return int'({busy_v[k], valid_v[k]});
    endfunction

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_seed(input int k, input int s);
        case (k)
            0:       sin0 = 4'(s);
            1:       sin1 = 5'(s);
            default: sin2 = 4'(s);
        endcase
    endtask

    task automatic reset_k(input int k);
        rst_v[k] = 1'b1;
        req_v[k] = 1'b0;
        tick();
        rst_v[k] = 1'b0;
        ms[k] = SD[k];
        mrnd[k] = 0;
        mrej[k] = 0;
        chk("rst_busy_valid", bv(k), 0);
        chk("rst_rnd", rnd_of(k), 0);
        chk("rst_rejects", int'(rej_v[k]), 0);
    endtask

    task automatic draw(input int k, output int got);
        int s, n, prev;
        bit ok;
        req_v[k] = 1'b1;
        tick();
        s = ms[k];
        if (FR[k] != 0) s = step(k, s);
        n = 0;
        ok = 1'b0;
        while (!ok && n < 4096) begin
            for (int i = 0; i < ST[k]; i++) s = step(k, s);
            n += ST[k] + 1;
            if (cand(k, s) < MX[k]) ok = 1'b1;
            else if (mrej[k] < 255) mrej[k]++;
        end
        ms[k] = s;
        prev = mrnd[k];
        mrnd[k] = cand(k, s);
        for (int i = 0; i < n; i++) begin
            chk("draw_busy", bv(k), 2);
            chk("draw_rnd_held", rnd_of(k), prev);
            req_v[k] = 1'($urandom_range(0, 1));
            tick();
        end
        req_v[k] = 1'b0;
        chk("draw_valid", bv(k), 1);
        chk("draw_rnd", rnd_of(k), mrnd[k]);
        chk("draw_rejects", int'(rej_v[k]), mrej[k]);
        got = rnd_of(k);
    endtask

    task automatic idle(input int k, input int n);
        req_v[k] = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (FR[k] != 0) ms[k] = step(k, ms[k]);
            chk("idle_busy_valid", bv(k), 0);
            chk("idle_rnd", rnd_of(k), mrnd[k]);
        end
    endtask

    task automatic seed(input int k, input int s, input bit with_req);
        set_seed(k, s);
        sl_v[k]  = 1'b1;
        req_v[k] = with_req;
        tick();
        sl_v[k]  = 1'b0;
        req_v[k] = 1'b0;
        ms[k] = (s == 0) ? SD[k] : s;
        mrej[k] = 0;
        chk("seed_busy_valid", bv(k), 0);
        chk("seed_rejects", int'(rej_v[k]), 0);
        chk("seed_rnd", rnd_of(k), mrnd[k]);
    endtask

    task automatic abort(input int k);
        int j;
        req_v[k] = 1'b1;
        tick();
        req_v[k] = 1'b0;
        j = $urandom_range(0, ST[k]);
        for (int i = 0; i < j; i++) begin
            chk("abort_busy", bv(k), 2);
            tick();
        end
        seed(k, $urandom_range(0, (1 << W[k]) - 1), 1'b0);
        idle(k, 1);
    endtask

    task automatic reset_mid(input int k);
        req_v[k] = 1'b1;
        tick();
        req_v[k] = 1'b0;
        chk("mid_busy", bv(k), 2);
        reset_k(k);
    endtask

    localparam int SEQ0 [6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        int got, op, seen;
        for (int k = 0; k < N; k++) begin
            rst_v[k] = 1'b1;
            sl_v[k]  = 1'b0;
            req_v[k] = 1'b0;
        end
        sin0 = '0;
        sin1 = '0;
        sin2 = '0;
        tick();
        tick();
        for (int k = 0; k < N; k++) rst_v[k] = 1'b0;
        for (int k = 0; k < N; k++) begin
            chk("por_busy_valid", bv(k), 0);
            chk("por_rnd", rnd_of(k), 0);
            chk("por_rejects", int'(rej_v[k]), 0);
        end

        for (int k = 0; k < N; k++) begin
            reset_k(k);
            if (k == 0) begin
                for (int i = 0; i < 6; i++) begin
                    draw(0, got);
                    chk("seq0", got, SEQ0[i]);
                    idle(0, 1);
                end
                chk("seq0_rejects", int'(rej_v[0]), 1);
                seed(0, 8, 1'b1);
                draw(0, got);
                chk("reseed8_rnd", got, 0);
                chk("reseed8_rejects", int'(rej_v[0]), 0);
                seed(0, 0, 1'b0);
                chk("seed0_state", ms[0], 1);
            end
            if (k == 2) begin
                seen = 0;
                for (int i = 0; i < 15; i++) begin
                    draw(2, got);
                    seen |= (1 << got);
                end
                chk("period_states", seen, 16'hFFFE);
                chk("period_rejects", int'(rej_v[2]), 0);
            end
            for (int it = 0; it < 60; it++) begin
                op = $urandom_range(0, 9);
                if (op <= 4)      draw(k, got);
                else if (op <= 6) idle(k, $urandom_range(1, 4));
                else if (op == 7) seed(k, ($urandom_range(0, 3) == 0) ? 0 :
                                          $urandom_range(0, (1 << W[k]) - 1),
                                       1'($urandom_range(0, 1)));
                else if (op == 8) abort(k);
                else              reset_mid(k);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1);
    end
endmodule
